// File: rtl/wb_mem_rsp_if.sv
// Wishbone classic-cycle bus bundle between a master and wb_mem_rsp.
// Signal names keep the responder's point of view (_i into the slave, _o out).
interface wb_mem_rsp_if;
    logic [31:0] wb_addr_i;
    logic [31:0] wb_data_i;
    logic [31:0] wb_data_o;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;

    modport slave (
        input  wb_addr_i, wb_data_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_data_o, wb_ack_o, wb_err_o, wb_rty_o
    );

    modport master (
        output wb_addr_i, wb_data_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_data_o, wb_ack_o, wb_err_o, wb_rty_o
    );
endinterface

// File: rtl/wb_mem_rsp.sv
// wb_mem_rsp: Wishbone classic-cycle responder backed by a 2^AW x 32 SRAM.
// Programmable wait states, address-window error, completed-access counter.
// Optional retry injection enabled by defining WB_MEM_RSP_RTY_EN: an access
// accepted with wait_cfg_i = 4'hF is terminated with rty instead of served.
module wb_mem_rsp #(
    parameter int          AW       = 14,
    parameter logic [31:0] BASE_ADR = 32'h0002_0000
) (
    input  logic           clk_i,
    input  logic           rst_i,
    wb_mem_rsp_if.slave    bus,
    input  logic [3:0]     wait_cfg_i,
    output logic [15:0]    acc_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      wcnt_q, wcnt_d;

    // Latched access attributes, captured when the access is accepted.
    logic [AW-1:0]   idx_q;
    logic            we_q;
    logic [3:0]      sel_q;
    logic [31:0]     wdat_q;
    logic            hit_q;
    logic            rtyp_q;

    // Registered bus outputs.
    logic            ack_q, err_q, rty_q;
    logic [31:0]     rdat_q;
    logic [15:0]     cnt_q;

    // Decoded per-cycle controls from the FSM.
    logic            accept;
    logic            ack_d, err_d, rty_d;
    logic            wr_en, rd_en;
    logic            rty_req;
    logic            hit_now;

    logic [31:0]     mem [2**AW];

    // Address bits below the word index never matter for a word memory.
    logic            unused_adr;
    assign unused_adr = ^bus.wb_addr_i[1:0];

`ifdef WB_MEM_RSP_RTY_EN
    assign rty_req = (wait_cfg_i == 4'hF);
`else
    assign rty_req = 1'b0;
`endif

    assign hit_now = (bus.wb_addr_i[31:AW+2] == BASE_ADR[31:AW+2]);

    // Next-state and termination decode; strobes are registered on the edge
    // that ends RESP, so they appear in the following (IDLE) cycle.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        accept  = 1'b0;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rty_d   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.wb_cyc_i && bus.wb_stb_i) begin
                    accept = 1'b1;
                    if (rty_req || (wait_cfg_i == 4'd0)) begin
                        state_d = RESP;
                    end else begin
                        wcnt_d  = wait_cfg_i;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // Master gave up: drop the access silently.
                if (!bus.wb_cyc_i) begin
                    state_d = IDLE;
                end else if (wcnt_q == 4'd1) begin
                    state_d = RESP;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (rtyp_q) begin
                    rty_d = 1'b1;
                end else if (hit_q) begin
                    ack_d = 1'b1;
                    wr_en = we_q;
                    rd_en = !we_q;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and wait counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            wcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Capture the accepted access so the master may change its bus afterwards.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idx_q  <= '0;
            we_q   <= 1'b0;
            sel_q  <= 4'd0;
            wdat_q <= 32'd0;
            hit_q  <= 1'b0;
            rtyp_q <= 1'b0;
        end else if (accept) begin
            idx_q  <= bus.wb_addr_i[AW+1:2];
            we_q   <= bus.wb_we_i;
            sel_q  <= bus.wb_sel_i;
            wdat_q <= bus.wb_data_i;
            hit_q  <= hit_now;
            rtyp_q <= rty_req;
        end
    end

    // Termination strobes, read data (zero except on a read ack) and counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            rty_q  <= 1'b0;
            rdat_q <= 32'd0;
            cnt_q  <= 16'd0;
        end else begin
            ack_q  <= ack_d;
            err_q  <= err_d;
            rty_q  <= rty_d;
            rdat_q <= rd_en ? mem[idx_q] : 32'd0;
            if (ack_d) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    // Byte-masked write, committed on the edge that ends RESP. Reset forces
    // the FSM out of RESP asynchronously, so a reset never lets a write land.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_q[b]) begin
                    mem[idx_q][8*b +: 8] <= wdat_q[8*b +: 8];
                end
            end
        end
    end

    assign bus.wb_ack_o  = ack_q;
    assign bus.wb_err_o  = err_q;
    assign bus.wb_rty_o  = rty_q;
    assign bus.wb_data_o = rdat_q;
    assign acc_cnt_o     = cnt_q;

endmodule

// File: tb/tb_wb_mem_rsp.sv
// Self-checking bench for wb_mem_rsp: directed vector table, hand-written
// abort/reset/retry sequences, then randomized accesses against a model.
module tb_wb_mem_rsp;

    logic        clk_i;
    logic        rst_i;
    logic [3:0]  wait_cfg_i;
    logic [15:0] acc_cnt_o;

    wb_mem_rsp_if bus ();

    wb_mem_rsp dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .bus        (bus),
        .wait_cfg_i (wait_cfg_i),
        .acc_cnt_o  (acc_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

`ifdef WB_MEM_RSP_RTY_EN
    localparam bit RTY_EN = 1'b1;
`else
    localparam bit RTY_EN = 1'b0;
`endif

    localparam int K_ACK = 0, K_ERR = 1, K_RTY = 2, K_NONE = 3;

    typedef struct {
        logic [31:0] a;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] d;
        logic [3:0]  w;
        int          kind;
        logic [31:0] rd;
        logic [15:0] cnt;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One classic-cycle access; returns termination kind, read data and the
    // number of edges from the accept edge to the edge that raised the strobe.
    task automatic access(input logic [31:0] a, input logic we, input logic [3:0] sel,
                          input logic [31:0] d, input logic [3:0] w,
                          output int kind, output logic [31:0] rd, output int lat);
        int nstb;
        @(negedge clk_i);
        bus.wb_addr_i = a;
        bus.wb_we_i   = we;
        bus.wb_sel_i  = sel;
        bus.wb_data_i = d;
        bus.wb_cyc_i  = 1'b1;
        bus.wb_stb_i  = 1'b1;
        wait_cfg_i    = w;
        @(posedge clk_i);
        #1 wait_cfg_i = 4'($urandom);
        kind = K_NONE;
        rd   = 32'd0;
        lat  = 0;
        for (int i = 0; i <= 40 && kind == K_NONE; i++) begin
            @(negedge clk_i);
            if (bus.wb_ack_o || bus.wb_err_o || bus.wb_rty_o) begin
                kind = bus.wb_ack_o ? K_ACK : (bus.wb_err_o ? K_ERR : K_RTY);
                rd   = bus.wb_data_o;
                lat  = i;
                nstb = int'(bus.wb_ack_o) + int'(bus.wb_err_o) + int'(bus.wb_rty_o);
                check("strobe exclusive", nstb, 1);
            end
        end
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        @(negedge clk_i);
        check("strobe one cycle", {bus.wb_ack_o, bus.wb_err_o, bus.wb_rty_o}, 3'b000);
        check("data zero after", bus.wb_data_o, 32'd0);
    endtask

    vec_t        vt [11];
    logic [31:0] ref_mem [8];
    logic [15:0] exp_cnt;
    int          kind, lat, ekind, elat, j;
    logic [31:0] rd, erd, a, d;
    logic [3:0]  sel, w;
    logic        we, miss, quiet;

    initial begin
        // Directed vectors with hand-derived expectations.
        vt[0]  = '{32'h0002_0010, 1'b1, 4'hF,    32'hDEAD_BEEF, 4'd0, K_ACK, 32'h0,         16'd1};
        vt[1]  = '{32'h0002_0010, 1'b0, 4'hF,    32'h0,         4'd0, K_ACK, 32'hDEAD_BEEF, 16'd2};
        vt[2]  = '{32'h0002_0010, 1'b1, 4'b0101, 32'h1122_3344, 4'd0, K_ACK, 32'h0,         16'd3};
        vt[3]  = '{32'h0002_0010, 1'b0, 4'hF,    32'h0,         4'd3, K_ACK, 32'hDE22_BE44, 16'd4};
        vt[4]  = '{32'h0002_0000, 1'b1, 4'hF,    32'h0BAD_F00D, 4'd1, K_ACK, 32'h0,         16'd5};
        vt[5]  = '{32'h0003_0000, 1'b0, 4'hF,    32'h0,         4'd0, K_ERR, 32'h0,         16'd5};
        vt[6]  = '{32'hB000_0000, 1'b1, 4'hF,    32'hFFFF_FFFF, 4'd2, K_ERR, 32'h0,         16'd5};
        vt[7]  = '{32'h0002_0000, 1'b0, 4'hF,    32'h0,         4'd0, K_ACK, 32'h0BAD_F00D, 16'd6};
        vt[8]  = '{32'h0002_FFFC, 1'b1, 4'hF,    32'hA5A5_5A5A, 4'd2, K_ACK, 32'h0,         16'd7};
        vt[9]  = '{32'h0002_FFFC, 1'b0, 4'hF,    32'h0,         4'd0, K_ACK, 32'hA5A5_5A5A, 16'd8};
        vt[10] = '{32'h0001_FFFC, 1'b0, 4'hF,    32'h0,         4'd4, K_ERR, 32'h0,         16'd8};

        rst_i         = 1'b0;
        bus.wb_addr_i = 32'd0;
        bus.wb_data_i = 32'd0;
        bus.wb_sel_i  = 4'd0;
        bus.wb_we_i   = 1'b0;
        bus.wb_cyc_i  = 1'b0;
        bus.wb_stb_i  = 1'b0;
        wait_cfg_i    = 4'd0;
        repeat (3) @(negedge clk_i);
        check("reset ack", bus.wb_ack_o, 1'b0);
        check("reset err", bus.wb_err_o, 1'b0);
        check("reset rty", bus.wb_rty_o, 1'b0);
        check("reset data", bus.wb_data_o, 32'd0);
        check("reset cnt", acc_cnt_o, 16'd0);
        rst_i = 1'b1;

        for (int i = 0; i < 11; i++) begin
            access(vt[i].a, vt[i].we, vt[i].sel, vt[i].d, vt[i].w, kind, rd, lat);
            check($sformatf("vec%0d kind", i), kind, vt[i].kind);
            check($sformatf("vec%0d data", i), rd, vt[i].rd);
            check($sformatf("vec%0d latency", i), lat, 32'(vt[i].w) + 32'd1);
            check($sformatf("vec%0d cnt", i), acc_cnt_o, vt[i].cnt);
        end
        exp_cnt = 16'd8;

        // Abort: W = 5 write, cyc dropped during the second wait cycle.
        @(negedge clk_i);
        bus.wb_addr_i = 32'h0002_0010; bus.wb_we_i = 1'b1; bus.wb_sel_i = 4'hF;
        bus.wb_data_i = 32'h0; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; wait_cfg_i = 4'd5;
        @(posedge clk_i);
        @(posedge clk_i);
        #1 bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        quiet = 1'b1;
        repeat (10) begin
            @(negedge clk_i);
            if (bus.wb_ack_o || bus.wb_err_o || bus.wb_rty_o) quiet = 1'b0;
        end
        check("abort no strobe", quiet, 1'b1);
        access(32'h0002_0010, 1'b0, 4'hF, 32'h0, 4'd0, kind, rd, lat);
        exp_cnt++;
        check("abort kind", kind, K_ACK);
        check("abort mem kept", rd, 32'hDE22_BE44);
        check("abort cnt", acc_cnt_o, exp_cnt);

        // wait_cfg_i = 4'hF: retry when enabled, 15 wait states otherwise.
        access(32'h0002_0010, 1'b1, 4'hF, 32'hCAFE_BABE, 4'hF, kind, rd, lat);
        if (RTY_EN) begin
            check("w15 kind", kind, K_RTY);
            check("w15 latency", lat, 1);
            check("w15 cnt", acc_cnt_o, exp_cnt);
            access(32'h0002_0010, 1'b0, 4'hF, 32'h0, 4'd0, kind, rd, lat);
            exp_cnt++;
            check("rty mem kept", rd, 32'hDE22_BE44);
            access(32'h0002_0010, 1'b1, 4'hF, 32'hCAFE_BABE, 4'd0, kind, rd, lat);
            exp_cnt++;
            check("rty resend kind", kind, K_ACK);
        end else begin
            exp_cnt++;
            check("w15 kind", kind, K_ACK);
            check("w15 latency", lat, 16);
        end
        access(32'h0002_0010, 1'b0, 4'hF, 32'h0, 4'd0, kind, rd, lat);
        exp_cnt++;
        check("w15 readback", rd, 32'hCAFE_BABE);
        check("w15 cnt", acc_cnt_o, exp_cnt);

        // Reset asserted mid-WAIT of a write.
        @(negedge clk_i);
        bus.wb_addr_i = 32'h0002_0010; bus.wb_we_i = 1'b1; bus.wb_sel_i = 4'hF;
        bus.wb_data_i = 32'h0; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; wait_cfg_i = 4'd5;
        @(posedge clk_i);
        @(posedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        check("rst wait ack", bus.wb_ack_o, 1'b0);
        check("rst wait err", bus.wb_err_o, 1'b0);
        check("rst wait rty", bus.wb_rty_o, 1'b0);
        check("rst wait data", bus.wb_data_o, 32'd0);
        check("rst wait cnt", acc_cnt_o, 16'd0);
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        exp_cnt = 16'd0;
        access(32'h0002_0010, 1'b0, 4'hF, 32'h0, 4'd0, kind, rd, lat);
        exp_cnt++;
        check("rst mem kept", rd, 32'hCAFE_BABE);
        check("rst then cnt", acc_cnt_o, exp_cnt);

        // Reset during the ack cycle clears the registered strobe at once.
        @(negedge clk_i);
        bus.wb_addr_i = 32'h0002_0010; bus.wb_we_i = 1'b0; bus.wb_sel_i = 4'hF;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; wait_cfg_i = 4'd0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        check("pre-rst ack", bus.wb_ack_o, 1'b1);
        check("pre-rst data", bus.wb_data_o, 32'hCAFE_BABE);
        #1 rst_i = 1'b0;
        #1;
        check("async ack clr", bus.wb_ack_o, 1'b0);
        check("async data clr", bus.wb_data_o, 32'd0);
        check("async cnt clr", acc_cnt_o, 16'd0);
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        exp_cnt = 16'd0;

        // Randomized phase: known contents first, then mixed traffic.
        for (int i = 0; i < 8; i++) begin
            ref_mem[i] = $urandom;
            access(32'h0002_0400 + 32'(4 * i), 1'b1, 4'hF, ref_mem[i], 4'd0, kind, rd, lat);
            exp_cnt++;
            check("init kind", kind, K_ACK);
        end
        for (int n = 0; n < 150; n++) begin
            j    = $urandom_range(0, 7);
            miss = ($urandom_range(0, 4) == 0);
            a    = miss ? {16'($urandom_range(3, 65535)), 16'h0400 + 16'(4 * j)}
                        : 32'h0002_0400 + 32'(4 * j);
            we   = 1'($urandom);
            sel  = 4'($urandom);
            d    = $urandom;
            w    = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 4));
            if (RTY_EN && w == 4'hF) begin
                ekind = K_RTY; elat = 1;
            end else begin
                ekind = miss ? K_ERR : K_ACK; elat = int'(w) + 1;
            end
            erd = (ekind == K_ACK && !we) ? ref_mem[j] : 32'd0;
            if (ekind == K_ACK) begin
                exp_cnt++;
                if (we) begin
                    for (int b = 0; b < 4; b++)
                        if (sel[b]) ref_mem[j][8*b +: 8] = d[8*b +: 8];
                end
            end
            access(a, we, sel, d, w, kind, rd, lat);
            check($sformatf("rnd%0d kind", n), kind, ekind);
            check($sformatf("rnd%0d data", n), rd, erd);
            check($sformatf("rnd%0d latency", n), lat, elat);
            check($sformatf("rnd%0d cnt", n), acc_cnt_o, exp_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            access(32'h0002_0400 + 32'(4 * i), 1'b0, 4'hF, 32'h0, 4'd1, kind, rd, lat);
            check($sformatf("final mem%0d", i), rd, ref_mem[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
